qsys_hex_blink_ctrl: RTL
========================

// Module: qsys_hex_blink_ctrl
// PURPOSE
//  Display-side stage downstream of the hour/minute PIO output ports.
//  - Takes the raw active-low 7-segment(+dp) patterns from those ports.
//  - Applies per-digit blinking (alarm/time-set feedback), global PWM dimming and global blanking.
//  - Drives the registered patterns to the HEX pins.
//  - No bus interface; all controls come from adjacent PIO outputs.
// PARAMETERS
//  NUM_DIGITS  4           number of 8-bit digit lanes
//  CLK_HZ      50_000_000  clk frequency in Hz
//  BLINK_HZ    2           blink rate; HALF = CLK_HZ/(2*BLINK_HZ) cycles per phase, must be >= 1
//  PWM_BITS    4           brightness/PWM counter width
// PORTS
//  clk         in   1             system clock
//  reset       in   1             asynchronous, active-high reset
//  seg_in      in   8*NUM_DIGITS  raw patterns, digit k = seg_in[8k+7:8k], active-low
//  blink_mask  in   NUM_DIGITS    1 = digit k blinks
//  brightness  in   PWM_BITS      duty level; 0 = dark, all-ones = full on
//  blank_all   in   1             1 = force every digit off
//  seg_out     out  8*NUM_DIGITS  registered patterns to HEX pins, active-low
//  blink_phase out  1             1 = blinking digits currently visible
// BEHAVIOUR
//  Clock and reset
//  - One clock domain: clk.
//  - reset is asynchronous and active-high.
//  - While reset is high: seg_out = all 8'hFF (dark), blink_phase = 1, prescaler = 0,
//    pwm_cnt = 0, mask_q = 0. All of this takes effect immediately, including mid-blink.
//  Prescaler
//  - Counts 0..HALF-1. On the cycle it is at HALF-1 it wraps to 0 and toggles blink_phase.
//  Mask change
//  - mask_q is a registered copy of blink_mask.
//  - If blink_mask != mask_q in a cycle, the next edge sets:
//    prescaler <= 0, blink_phase <= 1, mask_q <= blink_mask.
//  - Mask change takes priority over a simultaneous prescaler wrap.
//  PWM
//  - pwm_cnt is a free-running PWM_BITS-bit counter: +1 every cycle, wraps all-ones -> 0.
//  - pwm_on = (brightness == all-ones) | (pwm_cnt < brightness).
//  - Duty cycle is brightness / 2^PWM_BITS, except all-ones gives 100%.
//  Per digit k, registered on every edge
//  - off_k = blank_all | ~pwm_on | (mask_q[k] & ~blink_phase).
//  - seg_out[k] <= off_k ? 8'hFF : seg_in[k].
//  - Uses the current-cycle values of pwm_on, mask_q and blink_phase.
//  Latency
//  - seg_in / blank_all to seg_out: exactly 1 clk.
//  - blink_mask to effect: 2 clk (mask_q, then output register).
//  - seg_in is not registered internally and passes through unmodified when on.
//  Arithmetic
//  - Prescaler width is $clog2(HALF), minimum 1 bit.
//  - The PWM compare is unsigned, PWM_BITS wide.
//  Precedence
//  - blank_all > PWM off > blink hide > pass-through.
// TESTING  (CLK_HZ=20, BLINK_HZ=2 -> HALF=5; PWM_BITS=4; NUM_DIGITS=4)
//  1. Hold reset -> seg_out=32'hFFFFFFFF, blink_phase=1.
//     Release with seg_in=32'h40404040, brightness=15, mask=0 -> seg_out=32'h40404040 one clk later.
//  2. Set mask=4'b0001, brightness=15 -> digit0 shows 8'h40 for 5 clk, then 8'hFF for 5 clk, repeating.
//     Digits 1-3 stay 8'h40; blink_phase toggles every 5 clk.
//  3. Mid hidden phase, change mask 4'b0001 -> 4'b0010 -> blink_phase=1 and prescaler=0 next clk.
//     Digit0 is steady 8'h40 from then on; digit1 starts a fresh 5-clk visible phase.
//  4. brightness=4, mask=0 -> each digit shows 8'h40 on exactly 4 of every 16 clk.
//     brightness=0 -> constant 8'hFF.
//  5. blank_all=1 with brightness=15 -> all 8'hFF one clk later.
//     Drop blank_all -> patterns return one clk later.
//  6. Assert reset asynchronously mid-visible blink phase -> seg_out=8'hFF on all digits
//     immediately (before the next edge); after release the blink timing restarts from phase=1, count 0.

Source files
------------

// File: rtl/qsys_hex_blink_ctrl.sv
// rtl/qsys_hex_blink_ctrl.sv - per-digit blink, PWM dimming and blanking stage for HEX displays
module qsys_hex_blink_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_HZ     = 50_000_000,
  parameter int BLINK_HZ   = 2,
  parameter int PWM_BITS   = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [8*NUM_DIGITS-1:0] seg_in,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic [PWM_BITS-1:0]     brightness,
  input  logic                    blank_all,
  output logic [8*NUM_DIGITS-1:0] seg_out,
  output logic                    blink_phase
);

  // Cycles spent in each blink phase; prescaler is at least one bit wide.
  localparam int HALF = CLK_HZ / (2 * BLINK_HZ);
  localparam int PW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [PW-1:0] HALF_LAST = PW'(HALF - 1);

  logic [PW-1:0]           prescaler;
  logic [PWM_BITS-1:0]     pwm_cnt;
  logic [NUM_DIGITS-1:0]   mask_q;
  logic                    pwm_on;
  logic [NUM_DIGITS-1:0]   digit_off;
  logic [8*NUM_DIGITS-1:0] seg_next;

  // Full brightness bypasses the compare so all-ones means 100% duty.
  assign pwm_on = (brightness == {PWM_BITS{1'b1}}) | (pwm_cnt < brightness);

  // A digit is dark when blanked, in the PWM off slot, or blinking during the hidden phase.
  assign digit_off = {NUM_DIGITS{blank_all | ~pwm_on}}
                   | (mask_q & {NUM_DIGITS{~blink_phase}});

  // Raw pattern passes through unmodified unless the digit is forced dark.
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    assign seg_next[8*k +: 8] = digit_off[k] ? 8'hFF : seg_in[8*k +: 8];
  end

  // Blink prescaler, PWM counter, mask tracking and output register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescaler   <= '0;
      blink_phase <= 1'b1;
      mask_q      <= '0;
      pwm_cnt     <= '0;
      seg_out     <= '1;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      if (blink_mask != mask_q) begin
        // A new mask restarts blinking in the visible phase so the change shows at once.
        prescaler   <= '0;
        blink_phase <= 1'b1;
        mask_q      <= blink_mask;
      end else if (prescaler == HALF_LAST) begin
        prescaler   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        prescaler <= prescaler + 1'b1;
      end
      seg_out <= seg_next;
    end
  end

endmodule
